// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO write side between NUM_REQ producers.
// Optional stall counter output enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned MAX_BURST  = 4,
   localparam int unsigned OW         = $clog2(NUM_REQ),
   localparam int unsigned CW         = $clog2(MAX_BURST + 1)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
`ifdef FIFO_ARB_STALL_CNT_EN
   output logic [15:0]                   stall_cnt,
`endif
   output logic                          busy,
   output logic [OW-1:0]                 owner
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [OW-1:0]         r_owner;
   logic [OW-1:0]         w_owner_nxt;
   logic [CW-1:0]         r_burst_cnt;
   logic [CW-1:0]         w_burst_cnt_nxt;
   logic [OW-1:0]         w_pick;
   logic                  w_found;
   logic                  w_own_valid;
   logic [DATA_WIDTH-1:0] w_word [NUM_REQ];

   // Unpack the flat producer data bus into per-producer words
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign w_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   assign w_own_valid = req_valid[r_owner];

   // Round-robin search starting just after the current/last owner
   always_comb begin
      w_pick  = r_owner;
      w_found = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!w_found && req_valid[OW'((32'(r_owner) + k) % NUM_REQ)]) begin
            w_found = 1'b1;
            w_pick  = OW'((32'(r_owner) + k) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_owner     <= OW'(NUM_REQ - 1);
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

   // Next state plus the zero-latency FIFO-side handshake; IDLE is the all-off state
   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_burst_cnt_nxt = r_burst_cnt;
      req_ready       = '0;
      fifo_wr_en      = 1'b0;
      fifo_wr_data    = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_owner_nxt     = w_pick;
               w_burst_cnt_nxt = '0;
               w_state_nxt     = S_BURST;
            end
         end
         S_BURST: begin
            req_ready[r_owner] = !fifo_full;
            fifo_wr_en         = w_own_valid && !fifo_full;
            fifo_wr_data       = w_word[r_owner];
            if (!w_own_valid) begin
               w_state_nxt = S_IDLE;
            end else if (!fifo_full) begin
               w_burst_cnt_nxt = r_burst_cnt + CW'(1);
               if (r_burst_cnt == CW'(MAX_BURST - 1)) begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy  = (r_state == S_BURST);
   assign owner = r_owner;

`ifdef FIFO_ARB_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Saturating count of cycles where the owner has data but the FIFO is full
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_BURST) && w_own_valid && fifo_full &&
                   (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, async-reset and
// single-word-burst sequences, then random traffic against a transfer-level model.
module tb_fifo_wr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned MB = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          fifo_full;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;
   logic          busy;
   logic [1:0]    owner;

   logic [N-1:0]  v1;
   logic [N*DW-1:0] d1;
   logic [N-1:0]  ready1;
   logic          full1;
   logic          en1;
   logic [DW-1:0] wd1;
   logic          busy1;
   logic [1:0]    owner1;

`ifdef FIFO_ARB_STALL_CNT_EN
   logic [15:0]   stall_cnt;
   logic [15:0]   stall_cnt1;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
`ifdef FIFO_ARB_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .busy(busy), .owner(owner)
   );

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_data(d1),
      .req_ready(ready1), .fifo_full(full1), .fifo_wr_en(en1),
      .fifo_wr_data(wd1),
`ifdef FIFO_ARB_STALL_CNT_EN
      .stall_cnt(stall_cnt1),
`endif
      .busy(busy1), .owner(owner1)
   );

   typedef struct {
      logic [3:0]  v;
      logic        full;
      logic [31:0] d;
      logic [3:0]  ready;
      logic        en;
      logic [7:0]  wd;
      logic        busy;
      logic [1:0]  own;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [3:0] v, logic full, logic [31:0] d, logic [3:0] ready,
                               logic en, logic [7:0] wd, logic b, logic [1:0] own);
      vec_t r;
      r.v = v; r.full = full; r.d = d; r.ready = ready;
      r.en = en; r.wd = wd; r.busy = b; r.own = own;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] rdy, input logic en,
                          input logic [7:0] wd, input logic b, input logic [1:0] own);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
      chk({tag, ".fifo_wr_en"}, 32'(fifo_wr_en), 32'(en));
      chk({tag, ".fifo_wr_data"}, 32'(fifo_wr_data), 32'(wd));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".owner"}, 32'(owner), 32'(own));
   endtask

   // Transfer-level reference: whether a grant is open, who holds it, words taken so far
   bit          m_granted;
   int unsigned m_owner;
   int unsigned m_words;
   int unsigned m_stall;
   logic [3:0]  seq [N];

   function automatic logic [7:0] word_of(int unsigned i);
      return {4'(i), seq[i]};
   endfunction

   initial begin
      logic [3:0] e_rdy;
      logic       e_en;
      logic [7:0] e_wd;
      logic [3:0] rv;
      logic       rf;
      bit         found;

      reset_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
      v1 = '0; d1 = '0; full1 = 1'b0;

      // Single producer: 4-word burst, bubble, re-grant of the same producer
      vecs.push_back(mk(4'b0001, 0, 32'h000000AA, 4'b0000, 0, 8'h00, 0, 2'd3));
      vecs.push_back(mk(4'b0001, 0, 32'h000000AA, 4'b0001, 1, 8'hAA, 1, 2'd0));
      vecs.push_back(mk(4'b0001, 0, 32'h000000BB, 4'b0001, 1, 8'hBB, 1, 2'd0));
      vecs.push_back(mk(4'b0001, 0, 32'h000000CC, 4'b0001, 1, 8'hCC, 1, 2'd0));
      vecs.push_back(mk(4'b0001, 0, 32'h000000DD, 4'b0001, 1, 8'hDD, 1, 2'd0));
      vecs.push_back(mk(4'b0001, 0, 32'h000000EE, 4'b0000, 0, 8'h00, 0, 2'd0));
      vecs.push_back(mk(4'b0001, 0, 32'h000000EE, 4'b0001, 1, 8'hEE, 1, 2'd0));
      vecs.push_back(mk(4'b0000, 0, 32'h000000EE, 4'b0001, 0, 8'hEE, 1, 2'd0));
      vecs.push_back(mk(4'b0000, 0, 32'h000000EE, 4'b0000, 0, 8'h00, 0, 2'd0));
      // Owner 2 drops valid after two words while producer 3 waits
      vecs.push_back(mk(4'b1100, 0, 32'h30200000, 4'b0000, 0, 8'h00, 0, 2'd0));
      vecs.push_back(mk(4'b1100, 0, 32'h30200000, 4'b0100, 1, 8'h20, 1, 2'd2));
      vecs.push_back(mk(4'b1100, 0, 32'h30210000, 4'b0100, 1, 8'h21, 1, 2'd2));
      vecs.push_back(mk(4'b1000, 0, 32'h30210000, 4'b0100, 0, 8'h21, 1, 2'd2));
      vecs.push_back(mk(4'b1000, 0, 32'h30210000, 4'b0000, 0, 8'h00, 0, 2'd2));
      vecs.push_back(mk(4'b1000, 0, 32'h30210000, 4'b1000, 1, 8'h30, 1, 2'd3));
      vecs.push_back(mk(4'b0000, 0, 32'h30210000, 4'b1000, 0, 8'h30, 1, 2'd3));
      vecs.push_back(mk(4'b0000, 0, 32'h00000000, 4'b0000, 0, 8'h00, 0, 2'd3));
      // Owner 1 stalled by a full FIFO for 5 cycles after its second word
      vecs.push_back(mk(4'b0010, 0, 32'h00001100, 4'b0000, 0, 8'h00, 0, 2'd3));
      vecs.push_back(mk(4'b0010, 0, 32'h00001100, 4'b0010, 1, 8'h11, 1, 2'd1));
      vecs.push_back(mk(4'b0010, 0, 32'h00001200, 4'b0010, 1, 8'h12, 1, 2'd1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(4'b0010, 1, 32'h00001300, 4'b0000, 0, 8'h13, 1, 2'd1));
      vecs.push_back(mk(4'b0010, 0, 32'h00001300, 4'b0010, 1, 8'h13, 1, 2'd1));
      vecs.push_back(mk(4'b0010, 0, 32'h00001400, 4'b0010, 1, 8'h14, 1, 2'd1));
      vecs.push_back(mk(4'b0000, 0, 32'h00000000, 4'b0000, 0, 8'h00, 0, 2'd1));

      repeat (2) @(negedge clk);
      #1 chk_all("reset", 4'b0000, 0, 8'h00, 0, 2'd3);
      @(negedge clk) reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         req_valid = vecs[i].v; fifo_full = vecs[i].full; req_data = vecs[i].d;
         #1 chk_all($sformatf("vec%0d", i), vecs[i].ready, vecs[i].en, vecs[i].wd,
                    vecs[i].busy, vecs[i].own);
      end
`ifdef FIFO_ARB_STALL_CNT_EN
      chk("stall_cnt_after_stall", 32'(stall_cnt), 32'd5);
`endif

      // Asynchronous reset between edges during a burst
      @(negedge clk);
      req_valid = 4'b1111; req_data = 32'h44332211; fifo_full = 1'b0;
      #1 chk_all("rst_pre", 4'b0000, 0, 8'h00, 0, 2'd1);
      @(negedge clk);
      #1 chk_all("rst_burst", 4'b0100, 1, 8'h33, 1, 2'd2);
      #2 reset_n = 1'b0;
      #1 chk_all("rst_async", 4'b0000, 0, 8'h00, 0, 2'd3);
`ifdef FIFO_ARB_STALL_CNT_EN
      chk("stall_cnt_reset", 32'(stall_cnt), 32'd0);
`endif
      @(negedge clk) reset_n = 1'b1;
      #1 chk_all("rst_release", 4'b0000, 0, 8'h00, 0, 2'd3);
      @(negedge clk);
      #1 chk_all("rst_first_grant", 4'b0001, 1, 8'h11, 1, 2'd0);
      req_valid = '0;

      // MAX_BURST=1: one word per grant, bubble between each, order 0,1,2,3,0
      @(negedge clk);
      v1 = 4'b1111; d1 = 32'h33221100;
      for (int c = 0; c < 10; c++) begin
         logic [1:0] eo;
         logic       eb;
         if (c > 0) @(negedge clk);
         eb = (c % 2) == 1;
         eo = (c == 0) ? 2'd3 : 2'((c - 1) / 2);
         #1;
         chk($sformatf("mb1_c%0d.busy", c), 32'(busy1), 32'(eb));
         chk($sformatf("mb1_c%0d.owner", c), 32'(owner1), 32'(eo));
         chk($sformatf("mb1_c%0d.en", c), 32'(en1), 32'(eb));
         chk($sformatf("mb1_c%0d.data", c), 32'(wd1), eb ? 32'(8'h11 * eo) : 32'd0);
         chk($sformatf("mb1_c%0d.ready", c), 32'(ready1), eb ? 32'(4'b0001 << eo) : 32'd0);
      end
      v1 = '0;

      // Random traffic against the reference model, starting from a fresh reset
      @(negedge clk);
      req_valid = '0; fifo_full = 1'b0; reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      m_granted = 0; m_owner = N - 1; m_words = 0; m_stall = 0;
      for (int i = 0; i < N; i++) seq[i] = 4'(i * 3);
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         rv = 4'($urandom) | 4'($urandom);
         rf = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word_of(i);
         req_valid = rv; fifo_full = rf;
         e_rdy = (m_granted && !rf) ? 4'(4'b0001 << m_owner) : 4'b0000;
         e_en  = m_granted && rv[m_owner] && !rf;
         e_wd  = m_granted ? word_of(m_owner) : 8'h00;
         #1 chk_all($sformatf("rnd%0d", cyc), e_rdy, e_en, e_wd, m_granted, 2'(m_owner));
         for (int i = 0; i < N; i++)
            if (rv[i] && e_rdy[i]) seq[i] = seq[i] + 4'd1;
         if (m_granted && rv[m_owner] && rf && m_stall < 65535) m_stall++;
         if (!m_granted) begin
            if (rv != 4'b0000) begin
               found = 0;
               for (int k = 1; k <= N; k++)
                  if (!found && rv[(m_owner + k) % N]) begin
                     found = 1;
                     m_owner = (m_owner + k) % N;
                  end
               m_granted = 1; m_words = 0;
            end
         end else if (!rv[m_owner]) begin
            m_granted = 0;
         end else if (!rf) begin
            m_words++;
            if (m_words == MB) m_granted = 0;
         end
      end
`ifdef FIFO_ARB_STALL_CNT_EN
      @(negedge clk);
      #1 chk("stall_cnt_random", 32'(stall_cnt), 32'(m_stall));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
